// File: rtl/uart_pkg.sv
// Shared UART constants, FSM encoding and baud divisor table.
// Imported by the receiver, the transmitter and the baud controller.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int GAP_TICKS  = 512;
  localparam int DIV_W      = 24;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } rx_state_t;

  // round(clk_hz / (16 * baud)) for the eight selectable rates
  function automatic logic [DIV_W-1:0] baud_div(
    input int unsigned clk_hz,
    input logic [2:0]  sel
  );
    int unsigned baud;
    baud = 300;
    unique case (sel)
      3'd0: baud = 300;
      3'd1: baud = 1200;
      3'd2: baud = 4800;
      3'd3: baud = 9600;
      3'd4: baud = 19200;
      3'd5: baud = 38400;
      3'd6: baud = 57600;
      3'd7: baud = 115200;
    endcase
    baud_div = DIV_W'((clk_hz + 8 * baud) / (16 * baud));
  endfunction

endpackage

// File: rtl/baud_controller.sv
// Oversample tick generator: one-cycle pulse every divisor clocks.
// Shared by the UART receiver and transmitter.
module baud_controller
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       sample_ENABLE
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_div;

  assign w_div = baud_div(CLK_HZ, baud_select);

  // exact reload keeps the tick period fixed with no drift
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= '0;
      sample_ENABLE <= 1'b0;
    end else if (r_cnt == '0) begin
      r_cnt         <= w_div - DIV_W'(1);
      sample_ENABLE <= 1'b1;
    end else begin
      r_cnt         <= r_cnt - DIV_W'(1);
      sample_ENABLE <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_word_receiver.sv
// UART receiver assembling two 8E1 frames (low byte first)
// into a 16-bit word, with parity, framing and gap checks.
module uart_word_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  baud_select,
  input  logic        RX_EN,
  input  logic        RxD,
  output logic [15:0] data,
  output logic        Rx_VALID,
  output logic        Rx_PERROR,
  output logic        Rx_FERROR
);

  logic      w_tick;
  logic      w_fall;
  logic      w_mid;
  logic      r_sync1;
  logic      r_sync2;
  logic      r_prev;
  rx_state_t r_state;
  logic [3:0] r_tcnt;
  logic [2:0] r_bit;
  logic [8:0] r_gcnt;
  logic [7:0] r_shift;
  logic [7:0] r_low;
  logic       r_perr;
  logic       r_second;

  baud_controller #(
    .CLK_HZ(CLK_HZ)
  ) u_baud (
    .clk          (clk),
    .reset        (reset),
    .baud_select  (baud_select),
    .sample_ENABLE(w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= RxD;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;
  assign w_mid  = w_tick &&
                  (r_tcnt == 4'(OVERSAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tcnt    <= '0;
      r_bit     <= '0;
      r_gcnt    <= '0;
      r_shift   <= '0;
      r_low     <= '0;
      r_perr    <= 1'b0;
      r_second  <= 1'b0;
      data      <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
      if (!RX_EN) begin
        r_state  <= IDLE;
        r_second <= 1'b0;
        r_tcnt   <= '0;
        r_gcnt   <= '0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (w_fall) begin
              r_state <= START;
              r_tcnt  <= '0;
            end
          end
          // first tick after the edge counts as tick 0
          START: begin
            if (w_tick) begin
              if (r_tcnt == 4'd8) begin
                r_tcnt <= '0;
                r_bit  <= '0;
                if (r_sync2) begin
                  r_state  <= IDLE;
                  r_second <= 1'b0;
                end else begin
                  r_state <= DATA;
                end
              end else begin
                r_tcnt <= r_tcnt + 4'd1;
              end
            end
          end
          DATA: begin
            if (w_tick) begin
              r_tcnt <= r_tcnt + 4'd1;
            end
            if (w_mid) begin
              r_shift <= {r_sync2, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'(DATA_BITS - 1)) begin
                r_state <= PARITY;
              end
            end
          end
          PARITY: begin
            if (w_tick) begin
              r_tcnt <= r_tcnt + 4'd1;
            end
            if (w_mid) begin
              r_perr  <= ^{r_shift, r_sync2};
              r_state <= STOP;
            end
          end
          STOP: begin
            if (w_tick) begin
              r_tcnt <= r_tcnt + 4'd1;
            end
            if (w_mid) begin
              if (r_perr || !r_sync2) begin
                Rx_PERROR <= r_perr;
                Rx_FERROR <= ~r_sync2;
                r_second  <= 1'b0;
                r_state   <= IDLE;
              end else if (!r_second) begin
                r_low    <= r_shift;
                r_second <= 1'b1;
                r_gcnt   <= '0;
                r_state  <= GAP;
              end else begin
                data     <= {r_shift, r_low};
                Rx_VALID <= 1'b1;
                r_second <= 1'b0;
                r_state  <= IDLE;
              end
            end
          end
          GAP: begin
            if (w_fall) begin
              r_state <= START;
              r_tcnt  <= '0;
            end else if (w_tick) begin
              r_gcnt <= r_gcnt + 9'd1;
              if (r_gcnt == 9'(GAP_TICKS - 1)) begin
                Rx_FERROR <= 1'b1;
                r_second  <= 1'b0;
                r_state   <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
